// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared types and constants for the multi-pass shift sequencer
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic LR_RIGHT = 1'b0;
  localparam logic LR_LEFT  = 1'b1;
  localparam logic AL_LOGIC = 1'b0;
  localparam logic AL_ARITH = 1'b1;

  localparam int PASS_MAX_DEFAULT = 7;

  // Positions the shifter can take this pass: never more than remain, never more than pmax.
  function automatic logic [2:0] pass_amt(input int unsigned rem, input int unsigned pmax);
    return (rem < pmax) ? 3'(rem) : 3'(pmax);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - command and result handshake bundle of the shift sequencer
interface shift_seq_ctrl_if #(
  parameter int AMT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic [AMT_W-1:0] cmd_amt;
  logic             cmd_lr;
  logic             cmd_al;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [AMT_W-1:0] res_passes;

  modport master (
    output cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_al, res_ready,
    input  cmd_ready, res_valid, res_data, res_passes
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amt, cmd_lr, cmd_al, res_ready,
    output cmd_ready, res_valid, res_data, res_passes
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - feeds an 8-bit barrel shifter one pass per cycle to reach large shift amounts
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int AMT_W    = 4,
  parameter int PASS_MAX = PASS_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_seq_ctrl_if.slave     bus,
  output logic [7:0]          sh_din,
  output logic [2:0]          sh_shamt,
  output logic                sh_lr,
  output logic                sh_al,
  input  logic [7:0]          sh_dout,
  output logic                busy
);

  state_t           state, state_n;
  logic [7:0]       acc;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] passes;
  logic             lr, al;
  logic [2:0]       shamt;
  logic             cmd_ready, res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      passes <= '0;
      lr     <= 1'b0;
      al     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            acc    <= bus.cmd_data;
            rem    <= bus.cmd_amt;
            lr     <= bus.cmd_lr;
            al     <= bus.cmd_al;
            passes <= '0;
          end
        end
        SHIFT: begin
          acc    <= sh_dout;
          rem    <= rem - AMT_W'(shamt);
          passes <= passes + AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    shamt     = 3'd0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid)
          state_n = (bus.cmd_amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        shamt = pass_amt(int'(rem), PASS_MAX);
        if (rem == AMT_W'(shamt))
          state_n = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (bus.res_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outside SHIFT the shifter sees a zero shift, so sh_dout simply mirrors acc.
  assign sh_din   = acc;
  assign sh_shamt = shamt;
  assign sh_lr    = lr;
  assign sh_al    = al;

  assign bus.cmd_ready  = cmd_ready;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = acc;
  assign bus.res_passes = passes;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl with a barrel shifter model
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int AMT_W = 4;
  localparam int PMAX  = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       sh_din, sh_dout;
  logic [2:0]       sh_shamt;
  logic             sh_lr, sh_al, busy;

  int tests = 0;
  int fails = 0;

  shift_seq_ctrl_if #(.AMT_W(AMT_W)) bus ();

  shift_seq_ctrl #(.AMT_W(AMT_W), .PASS_MAX(PMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sh_din   (sh_din),
    .sh_shamt (sh_shamt),
    .sh_lr    (sh_lr),
    .sh_al    (sh_al),
    .sh_dout  (sh_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural barrel shifter standing in for the real one at the parent level.
  always_comb begin
    if (sh_lr) sh_dout = sh_din << sh_shamt;
    else if (sh_al) sh_dout = 8'($signed(sh_din) >>> sh_shamt);
    else sh_dout = sh_din >> sh_shamt;
  end

  // Whole shift in one step, straight from the operation's definition.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic lr, input logic al);
    int v;
    if (lr) return (amt >= 8) ? 8'h00 : 8'(int'(d) << amt);
    if (al && d[7]) v = int'(d) - 256;
    else v = int'(d);
    if (amt >= 8) return (al && d[7]) ? 8'hFF : 8'h00;
    return 8'(v >>> amt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d, input logic [3:0] amt, input logic lr, input logic al, input string tag);
    @(negedge clk);
    check({tag, "/cmd_ready_before"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_data  = d;
    bus.cmd_amt   = amt;
    bus.cmd_lr    = lr;
    bus.cmd_al    = al;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'($urandom);
    bus.cmd_amt   = 4'($urandom);
    bus.cmd_lr    = 1'($urandom);
    bus.cmd_al    = 1'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] d, input logic [3:0] amt, input logic lr, input logic al,
                         input logic [7:0] exp_d, input int exp_p, input string tag);
    int lat, sumsh, npass, want;
    bit got;
    lat = 1; sumsh = 0; npass = 0; got = 0;
    issue(d, amt, lr, al, tag);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.res_valid) got = 1;
      else begin
        want = (int'(amt) - sumsh < PMAX) ? int'(amt) - sumsh : PMAX;
        check({tag, "/pass_shamt"}, 32'(sh_shamt), 32'(want));
        check({tag, "/pass_din"}, 32'(sh_din), 32'(ref_shift(d, sumsh, lr, al)));
        check({tag, "/pass_lr"}, 32'(sh_lr), 32'(lr));
        sumsh += int'(sh_shamt);
        npass++;
        @(posedge clk);
        lat++;
      end
    end
    check({tag, "/res_valid_seen"}, 32'(got), 32'd1);
    check({tag, "/latency"}, 32'(lat), 32'(exp_p + 1));
    check({tag, "/pass_count"}, 32'(npass), 32'(exp_p));
    check({tag, "/res_data"}, 32'(bus.res_data), 32'(exp_d));
    check({tag, "/res_passes"}, 32'(bus.res_passes), 32'(exp_p));
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check({tag, "/idle_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "/idle_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "/idle_shamt"}, 32'(sh_shamt), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [3:0] amt;
    logic       lr;
    logic       al;
    logic [7:0] exp_d;
    int         exp_p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ad, ap;
    logic [7:0] rd, held_d;
    logic [3:0] ramt;
    logic rlr, ral;
    bit got;

    vecs[0] = '{8'hB4, 4'd3,  LR_RIGHT, AL_LOGIC, 8'h16, 1};
    vecs[1] = '{8'hB4, 4'd10, LR_RIGHT, AL_ARITH, 8'hFF, 2};
    vecs[2] = '{8'hB4, 4'd10, LR_RIGHT, AL_LOGIC, 8'h00, 2};
    vecs[3] = '{8'h01, 4'd15, LR_LEFT,  AL_LOGIC, 8'h00, 3};
    vecs[4] = '{8'h5A, 4'd0,  LR_RIGHT, AL_LOGIC, 8'h5A, 0};
    vecs[5] = '{8'h81, 4'd9,  LR_LEFT,  AL_LOGIC, 8'h00, 2};

    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_amt = '0;
    bus.cmd_lr = 1'b0; bus.cmd_al = 1'b0; bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset/cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset/res_valid", 32'(bus.res_valid), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/res_data", 32'(bus.res_data), 32'd0);
    check("reset/res_passes", 32'(bus.res_passes), 32'd0);
    check("reset/sh_shamt", 32'(sh_shamt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].d, vecs[i].amt, vecs[i].lr, vecs[i].al, vecs[i].exp_d, vecs[i].exp_p,
              $sformatf("vec%0d", i));

    // Result held under backpressure; a command offered meanwhile must be dropped.
    issue(8'hB4, 4'd3, LR_RIGHT, AL_LOGIC, "bp");
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.res_valid) got = 1;
    end
    check("bp/res_valid_seen", 32'(got), 32'd1);
    held_d = bus.res_data;
    check("bp/res_data", 32'(held_d), 32'h16);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.cmd_valid = 1'b1; bus.cmd_data = 8'h5A; bus.cmd_amt = 4'd0;
      end else bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp/hold_valid", 32'(bus.res_valid), 32'd1);
      check("bp/hold_data", 32'(bus.res_data), 32'(held_d));
      check("bp/hold_passes", 32'(bus.res_passes), 32'd1);
      check("bp/hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check("bp/after_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("bp/after_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bp/dropped_cmd_no_result", 32'(bus.res_valid), 32'd0);

    // Asynchronous reset in the middle of a multi-pass shift.
    issue(8'h01, 4'd15, LR_LEFT, AL_LOGIC, "abort");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort/res_valid", 32'(bus.res_valid), 32'd0);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort/sh_shamt", 32'(sh_shamt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_cmd(8'h81, 4'd9, LR_LEFT, AL_LOGIC, 8'h00, 2, "after_abort");

    for (int i = 0; i < 30; i++) begin
      rd   = 8'($urandom);
      ramt = 4'($urandom_range(0, 15));
      rlr  = 1'($urandom);
      ral  = 1'($urandom);
      ad   = int'(ramt);
      ap   = (ad + PMAX - 1) / PMAX;
      run_cmd(rd, ramt, rlr, ral, ref_shift(rd, ad, rlr, ral), ap, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
